jpeg_go_scheduler: RTL
======================

# jpeg_go_scheduler

Round-robin scheduler that shares one start-pulse-driven engine (e.g. a JPEG encode core launched through a go/done pulse pair, possibly across a go-pulse clock-domain crossing) among NREQ requesters. It arbitrates level requests, issues a single-cycle `go`, holds the grant until the engine's `done_i` pulse or a timeout, and enforces a minimum spacing between consecutive `go` pulses so a toggle-based pulse synchronizer downstream never merges two starts. It sits in the control clock domain, directly in front of the go-pulse CDC.

## Interface
- NREQ, 4: number of requesters, 2..16.
- MIN_GAP, 4: minimum cycles between consecutive `go` pulses, ≥1; sized by the integrator for the CDC clock ratio.
- TIMEOUT, 0: cycles allowed in BUSY before forced abort; 0 disables.

- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  level request per requester; held until `req_done` or until the requester gives up.
- done_i  in  1  engine completion pulse, already in the `clk` domain.
- go  out  1  engine start pulse, exactly one cycle.
- gnt  out  NREQ  one-hot grant, held from the `go` cycle through the last BUSY cycle.
- gnt_id  out  clog2(NREQ)  binary index of the current or last grant.
- busy  out  1  high while in BUSY.
- req_done  out  NREQ  one-cycle completion pulse to the granted requester.
- timeout  out  1  one-cycle pulse on forced abort.

## Operation
- Reset: the reset value of every output is 0. State goes to IDLE. RR pointer goes to 0. Gap counter goes to 0.
- States: IDLE, BUSY.
- IDLE: if any `req` bit is set and the gap counter is 0:
  - Select the winner by searching from the pointer upward, modulo NREQ.
  - Next cycle: `go`=1 for one cycle, `gnt`/`gnt_id` = winner, `busy`=1, state = BUSY.
  - Pointer = winner+1 mod NREQ.
  - Gap counter loads MIN_GAP-1.
- Gap counter: decrements by 1 each cycle while nonzero, independent of state. It saturates at 0.
- BUSY, on `done_i`=1:
  - Next cycle: `req_done[gnt_id]`=1 for one cycle, `gnt`=0, `busy`=0, state = IDLE.
  - `gnt_id` keeps its value.
- BUSY timeout, only when TIMEOUT>0:
  - A cycle counter clears on `go` and increments each BUSY cycle.
  - When it equals TIMEOUT with no `done_i`: next cycle `timeout`=1, `gnt`=0, `busy`=0, state = IDLE.
  - No `req_done` is issued.
  - If `done_i` arrives in the same cycle as the timeout, `done_i` wins.
- `done_i` is ignored in IDLE, including late dones after a timeout. It is also ignored in the cycle `go` is high.
- Deasserting `req` during BUSY does not cancel. The grant runs to done/timeout and `req_done` still pulses.
- `req` still high after `req_done` is re-arbitrated normally. The RR pointer guarantees the other requesters are served first.
- Widths: gap counter clog2(MIN_GAP+1) bits. Timeout counter clog2(TIMEOUT+1) bits, minimum 1.

## Timing
- Request to `go`: 1 cycle. `req` is sampled in cycle t, and `go` and `gnt` appear in t+1, provided IDLE and gap counter 0.
- `done_i` to `req_done`/`gnt` release: 1 cycle.
- Earliest re-grant: the cycle after release, registered, so `go` comes 2 cycles after `done_i`. Spacing between `go` pulses is ≥ max(MIN_GAP, 3).
- Simultaneous: `done_i` in cycle d with new `req` in d → evaluated in d+1 (IDLE), `go` in d+2, subject to the gap.
- Reset asserted mid-BUSY: the next cycle has all outputs 0 and state IDLE. No `req_done` or `timeout` is emitted for the aborted grant.

## Test plan
- Single request: reset, then `req`=4'b0010 at cycle 5 → `go` at 6, `gnt`=0010, `gnt_id`=1. Drive `done_i` at 10 → `req_done`=0010 at 11, `busy`=0 at 11.
- Round-robin: `req`=4'b1111 held, `done_i` 2 cycles after each `go` → grant order 0,1,2,3,0. No requester is served twice before all are served.
- Gap enforcement: MIN_GAP=8, `req`=0001 held, `done_i` the cycle after `go`'s next cycle → successive `go` rising edges exactly 8 cycles apart.
- Timeout: TIMEOUT=16, grant requester 2, no `done_i` → `timeout` pulses 17 cycles after `go`, with no `req_done`. A `done_i` injected 5 cycles later is ignored, and `busy` stays 0 when `req`=0.
- Requester withdraws: grant requester 3, drop `req[3]` in BUSY → `gnt` held. `done_i` → `req_done`=1000. No re-grant to 3.
- Reset mid-operation: assert `rst` 3 cycles after `go` → next cycle all outputs 0. Release with `req`=1111 → grant goes to requester 0, because the pointer was reset.

Source files
------------

// File: rtl/jpeg_go_scheduler_if.sv
// ---------------------------------------------------------------------------
// jpeg_go_scheduler_if
// Request/grant and engine go/done signals shared between the requesters,
// the engine launch path and the round-robin go scheduler.
// ---------------------------------------------------------------------------
interface jpeg_go_scheduler_if #(
    parameter int NREQ = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0] req;       // level request per requester
    logic            done_i;    // engine completion pulse (clk domain)
    logic            go;        // single-cycle engine start
    logic [NREQ-1:0] gnt;       // one-hot grant, held through BUSY
    logic [IDW-1:0]  gnt_id;    // index of current / last grant
    logic            busy;      // engine owned by a requester
    logic [NREQ-1:0] req_done;  // completion pulse to the granted requester
    logic            timeout;   // forced-abort pulse

    // Requesters and the engine side
    modport master (
        output req, done_i,
        input  go, gnt, gnt_id, busy, req_done, timeout
    );

    // Scheduler side
    modport slave (
        input  req, done_i,
        output go, gnt, gnt_id, busy, req_done, timeout
    );
endinterface

// File: rtl/jpeg_go_scheduler.sv
// ---------------------------------------------------------------------------
// jpeg_go_scheduler
// Round-robin sharing of one go/done-launched engine among NREQ requesters.
// A grant is issued with a single-cycle go, held until done_i (or an optional
// BUSY timeout), and consecutive go pulses are spaced at least MIN_GAP cycles
// apart so a toggle-based go synchronizer downstream never merges two starts.
// ---------------------------------------------------------------------------
module jpeg_go_scheduler #(
    parameter int NREQ    = 4,   // 2..16 requesters
    parameter int MIN_GAP = 4,   // minimum cycles between go pulses, >= 1
    parameter int TIMEOUT = 0    // BUSY cycles before abort, 0 disables
) (
    input  logic                clk,
    input  logic                rst,
    jpeg_go_scheduler_if.slave  bus
);

    localparam int IDW = $clog2(NREQ);
    localparam int GW  = $clog2(MIN_GAP + 1);
    localparam int TW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam bit             TO_EN    = (TIMEOUT > 0);
    localparam logic [TW-1:0]  TO_LIMIT = TW'(TIMEOUT);
    localparam logic [GW-1:0]  GAP_LOAD = GW'(MIN_GAP - 1);
    localparam logic [IDW-1:0] LAST_ID  = IDW'(NREQ - 1);
    localparam logic [IDW:0]   NREQ_W   = (IDW + 1)'(NREQ);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t          r_state;
    logic [IDW-1:0]  r_ptr;       // round-robin search start
    logic [GW-1:0]   r_gap;       // cycles left before another go is allowed
    logic [TW-1:0]   r_tcnt;      // BUSY cycles since go
    logic            r_go;
    logic [NREQ-1:0] r_gnt;
    logic [IDW-1:0]  r_gnt_id;
    logic            r_busy;
    logic [NREQ-1:0] r_req_done;
    logic            r_timeout;

    logic [2*NREQ-1:0] w_req_dbl;  // requests repeated so a slice is a rotation
    logic [NREQ-1:0]   w_req_rot;  // requests rotated so r_ptr sits at bit 0
    logic [IDW-1:0]    w_off;      // winner offset from r_ptr
    logic              w_win_valid;
    logic [IDW:0]      w_sum;
    logic [IDW-1:0]    w_win_id;
    logic [IDW-1:0]    w_ptr_next;
    logic [NREQ-1:0]   w_win_onehot;

    assign w_req_dbl = {bus.req, bus.req};
    assign w_req_rot = w_req_dbl[r_ptr +: NREQ];

    // Find the first pending request at or above the pointer (wrapping).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        w_win_valid = 1'b0;
        w_off       = '0;
        // Walk downward so the lowest offset is the last (winning) assignment.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_req_rot[i]) begin
                w_win_valid = 1'b1;
                w_off       = IDW'(i);
            end
        end
    end

    // Convert the rotated offset back to an absolute requester index.
    assign w_sum        = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_win_id     = (w_sum >= NREQ_W) ? IDW'(w_sum - NREQ_W) : w_sum[IDW-1:0];
    assign w_ptr_next   = (w_win_id == LAST_ID) ? '0 : w_win_id + 1'b1;
    assign w_win_onehot = {{(NREQ-1){1'b0}}, 1'b1} << w_win_id;

    // Scheduler FSM with registered outputs, gap and timeout counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_gap      <= '0;
            r_tcnt     <= '0;
            r_go       <= 1'b0;
            r_gnt      <= '0;
            r_gnt_id   <= '0;
            r_busy     <= 1'b0;
            r_req_done <= '0;
            r_timeout  <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low here and are overridden below with
            // non-blocking assignments, so each pulse lasts exactly one cycle.
            r_go       <= 1'b0;
            r_req_done <= '0;
            r_timeout  <= 1'b0;

            // The gap counter runs down in any state and saturates at 0.
            if (r_gap != '0) begin
                r_gap <= r_gap - 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_win_valid && (r_gap == '0)) begin
                        r_state  <= S_BUSY;
                        r_go     <= 1'b1;
                        r_gnt    <= w_win_onehot;
                        r_gnt_id <= w_win_id;
                        r_busy   <= 1'b1;
                        r_ptr    <= w_ptr_next;
                        r_gap    <= GAP_LOAD;
                        r_tcnt   <= '0;
                    end
                end

                S_BUSY: begin
                    if (TO_EN) begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                    // done_i in the go cycle belongs to no launched job; a done
                    // coinciding with the timeout limit still completes normally.
                    if (!r_go && bus.done_i) begin
                        r_state    <= S_IDLE;
                        r_req_done <= r_gnt;
                        r_gnt      <= '0;
                        r_busy     <= 1'b0;
                    end else if (TO_EN && (r_tcnt == TO_LIMIT)) begin
                        r_state   <= S_IDLE;
                        r_timeout <= 1'b1;
                        r_gnt     <= '0;
                        r_busy    <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.go       = r_go;
    assign bus.gnt      = r_gnt;
    assign bus.gnt_id   = r_gnt_id;
    assign bus.busy     = r_busy;
    assign bus.req_done = r_req_done;
    assign bus.timeout  = r_timeout;

endmodule
